// File: rtl/cal_qcol_pkg.sv
// cal_qcol_pkg: shared widths, constants, state encodings and the
// round/saturate helper for the Q-column normalisation stage.
package cal_qcol_pkg;

  localparam int H_W       = 24;  // h lane, signed 2.22
  localparam int R_W       = 20;  // Rii, unsigned 4.16
  localparam int RECIP_W   = 24;  // 1/Rii, unsigned 4.20
  localparam int Q_W       = 16;  // q lane, signed 2.14
  localparam int DIV_ITERS = 24;  // one quotient bit per cycle

  localparam logic [RECIP_W-1:0] RECIP_SAT    = 24'hFFFFFF;
  localparam logic [R_W-1:0]     RECIP_SAT_TH = 20'h01000;

  typedef logic [1:0] qcol_state_t;

  localparam qcol_state_t QCOL_IDLE = 2'd0;
  localparam qcol_state_t QCOL_DIV  = 2'd1;
  localparam qcol_state_t QCOL_MUL  = 2'd2;

  // pr = product bits [47:27] of the 6.42 product: [20:1] is the 2.14 value
  // with integer headroom, [0] is the first dropped bit (round half up).
  function automatic logic [Q_W-1:0] round_sat(input logic [20:0] pr);
    logic signed [20:0] r;
    r = $signed({pr[20], pr[20:1]}) + $signed({20'b0, pr[0]});
    if (r > 21'sd32767)       return 16'h7FFF;
    else if (r < -21'sd32768) return 16'h8000;
    else                      return r[15:0];
  endfunction

endpackage

// File: rtl/cal_qcol_recip_div_seq.sv
// recip_div_seq: fixed 24-cycle restoring divider computing 2^36 / rii.
// start is a one-cycle strobe; done is high during the last iteration cycle
// and recip is updated on the edge that ends it. Small divisors
// (rii <= RECIP_SAT_TH, including 0) return RECIP_SAT without changing latency.
module recip_div_seq
  import cal_qcol_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [R_W-1:0]     rii,
  output logic               done,
  output logic [RECIP_W-1:0] recip
);

  logic [R_W-1:0]     rii_q;
  logic [R_W:0]       rem;
  logic [RECIP_W-1:0] quo;
  logic [4:0]         cnt;
  logic               busy;
  logic               sat;

  logic [R_W:0]       rem_sh;
  logic               take;
  logic [R_W:0]       rem_nx;

  // One restoring step: shift in the next (zero) dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem[R_W-1:0], 1'b0};
    take   = (rem_sh >= {1'b0, rii_q});
    rem_nx = take ? (rem_sh - {1'b0, rii_q}) : rem_sh;
  end

  assign done = busy && (cnt == 5'(DIV_ITERS - 1));

  // Iteration state; the remainder starts at 2^36 >> 24 so 24 steps give bits 23..0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rii_q <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      sat   <= 1'b0;
      recip <= '0;
    end else if (start) begin
      rii_q <= rii;
      rem   <= 21'h01000;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      sat   <= (rii <= RECIP_SAT_TH);
    end else if (busy) begin
      rem <= rem_nx;
      quo <= {quo[RECIP_W-2:0], take};
      cnt <= cnt + 5'd1;
      if (done) begin
        busy  <= 1'b0;
        recip <= sat ? RECIP_SAT : {quo[RECIP_W-2:0], take};
      end
    end
  end

endmodule

// File: rtl/cal_qcol.sv
// cal_qcol: Q-column normalisation, q = h / Rii, fixed 33-cycle latency.
// Reciprocal from a sequential divider, then one shared multiplier walks the
// 8 lanes (re0 first). Optional build macro: QCOL_ZERO_GUARD_EN (Rii == 0
// yields an all-zero column and an o_singular pulse).
//
// Handshake: Rii_valid is a one-cycle strobe accepted only while o_ready is
// high (IDLE); a strobe while not ready is dropped and sets sticky o_overrun.
// Each accepted job produces exactly one o_q_valid pulse 33 cycles later;
// o_q_column holds its value until the next result.
module cal_qcol
  import cal_qcol_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [R_W-1:0]       Rii,
  input  logic                 Rii_valid,
  input  logic [LANES*H_W-1:0] h_column,
  output logic                 o_ready,
  output logic [LANES*Q_W-1:0] o_q_column,
  output logic                 o_q_valid,
  output logic                 o_overrun,
  output logic                 o_singular,
  output qcol_state_t          dbg_state
);

  qcol_state_t          state;
  logic [2:0]           lane;
  logic [LANES*H_W-1:0] h_reg;
  logic [LANES*Q_W-1:0] shadow;

  logic                 start;
  logic                 div_done;
  logic [RECIP_W-1:0]   recip;

  logic signed [H_W-1:0] h_k;
  logic signed [47:0]    prod;
  logic                  prod_lsb_unused;
  logic [Q_W-1:0]        q_k;
  logic [Q_W-1:0]        q_lane;
  logic                  finishing;

  assign o_ready   = (state == QCOL_IDLE);
  assign dbg_state = state;
  assign start     = (state == QCOL_IDLE) && Rii_valid;
  assign finishing = (state == QCOL_MUL) && (lane == 3'(LANES - 1));

  recip_div_seq u_div (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .start (start),
    .rii   (Rii),
    .done  (div_done),
    .recip (recip)
  );

  // Shared multiplier: current lane times the unsigned reciprocal, 6.42 result
  always_comb begin
    h_k  = h_reg[lane*H_W +: H_W];
    prod = 48'($signed(h_k)) * 48'($signed({1'b0, recip}));
    q_k  = round_sat(prod[47:27]);
  end

  assign prod_lsb_unused = ^prod[26:0];

`ifdef QCOL_ZERO_GUARD_EN
  logic rii_zero;

  // Remember whether the accepted Rii was zero so its column is forced to zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   rii_zero <= 1'b0;
    else if (start) rii_zero <= (Rii == '0);
  end

  assign q_lane = rii_zero ? '0 : q_k;

  // Singular flag pulses alongside o_q_valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_singular <= 1'b0;
    else          o_singular <= finishing && rii_zero;
  end
`else
  assign q_lane     = q_k;
  assign o_singular = 1'b0;
`endif

  // Control FSM, lane sequencing, shadow fill and result transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= QCOL_IDLE;
      lane       <= '0;
      h_reg      <= '0;
      shadow     <= '0;
      o_q_column <= '0;
      o_q_valid  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_q_valid <= 1'b0;
      if (Rii_valid && (state != QCOL_IDLE)) o_overrun <= 1'b1;
      case (state)
        QCOL_IDLE: begin
          if (Rii_valid) begin
            h_reg <= h_column;
            state <= QCOL_DIV;
          end
        end
        QCOL_DIV: begin
          if (div_done) begin
            lane  <= '0;
            state <= QCOL_MUL;
          end
        end
        QCOL_MUL: begin
          shadow[lane*Q_W +: Q_W] <= q_lane;
          lane <= lane + 3'd1;
          if (finishing) begin
            // Last lane goes straight to the output alongside the shadow
            o_q_column <= {q_lane, shadow[(LANES-1)*Q_W-1:0]};
            o_q_valid  <= 1'b1;
            state      <= QCOL_IDLE;
          end
        end
        default: state <= QCOL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_qcol.sv
// tb_cal_qcol: directed vectors for cal_qcol with a scoreboard queue.
// Expected {due cycle, singular, q column} is pushed when a job is issued;
// the monitor pops and compares on every o_q_valid.
module tb_cal_qcol;
  import cal_qcol_pkg::*;

  localparam int EW = 32 + 1 + 128;
`ifdef QCOL_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [19:0]   Rii = '0;
  logic          Rii_valid = 1'b0;
  logic [191:0]  h_column = '0;
  logic          o_ready;
  logic [127:0]  o_q_column;
  logic          o_q_valid;
  logic          o_overrun;
  logic          o_singular;
  qcol_state_t   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valids_seen = 0;
  logic [EW-1:0] exp_q[$];

  cal_qcol dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .Rii        (Rii),
    .Rii_valid  (Rii_valid),
    .h_column   (h_column),
    .o_ready    (o_ready),
    .o_q_column (o_q_column),
    .o_q_valid  (o_q_valid),
    .o_overrun  (o_overrun),
    .o_singular (o_singular),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Drive a one-cycle strobe; accepted jobs push their expected result
  task automatic send(input logic [19:0] r, input logic [191:0] h, input bit accept,
                      input logic [127:0] q, input bit sing);
    Rii       = r;
    h_column  = h;
    Rii_valid = 1'b1;
    if (accept) exp_q.push_back({32'(cyc + 33), sing, q});
    @(posedge i_clk);
    #1;
    Rii_valid = 1'b0;
  endtask

  // Monitor: pop and compare on every result strobe
  always @(negedge i_clk) begin
    logic [EW-1:0] e;
    if (i_rst_n && o_q_valid) begin
      valids_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cyc=%0d got=%h want=none", cyc, o_q_column);
      end else begin
        e = exp_q.pop_front();
        check("latency", 192'(cyc), 192'(e[EW-1:129]));
        check("q_column", 192'(o_q_column), 192'(e[127:0]));
        check("singular", 192'(o_singular), 192'(e[128]));
      end
    end
  end

  // Directed stimulus
  initial begin
    int c;
    int v0;
    logic [191:0] h1, h2, h3, h4;
    logic [127:0] q1, q2, q3, q0, q4;

    h1 = {168'b0, 24'h200000};               q1 = {112'b0, 16'h2000};
    h2 = {8{24'hC00000}};                    q2 = {8{16'hE000}};
    h3 = {144'b0, 24'hC00000, 24'h400000};   q3 = {96'b0, 16'h8000, 16'h7FFF};
    q0 = GUARD ? 128'b0 : q3;
    h4 = {144'b0, 24'hF00000, 24'h100000};   q4 = {96'b0, 16'hF555, 16'h0AAB};

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", 192'(o_q_valid), 192'(0));
    check("rst_column", 192'(o_q_column), 192'(0));
    check("rst_overrun", 192'(o_overrun), 192'(0));
    check("rst_singular", 192'(o_singular), 192'(0));
    check("rst_ready", 192'(o_ready), 192'(1));
    check("rst_state", 192'(dbg_state), 192'(QCOL_IDLE));
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Unity Rii
    c = cyc;
    send(20'h10000, h1, 1'b1, q1, 1'b0);
    goto(c + 5);
    check("busy_ready", 192'(o_ready), 192'(0));
    check("busy_state", 192'(dbg_state), 192'(QCOL_DIV));
    goto(c + 34);
    check("recip_unity", 192'(dut.u_div.recip), 192'(24'h100000));
    check("idle_ready", 192'(o_ready), 192'(1));

    // Rii = 2, negative lanes
    c = cyc;
    send(20'h20000, h2, 1'b1, q2, 1'b0);
    goto(c + 34);
    check("recip_two", 192'(dut.u_div.recip), 192'(24'h080000));

    // Threshold divisor saturates the reciprocal and the lanes
    c = cyc;
    send(20'h01000, h3, 1'b1, q3, 1'b0);
    goto(c + 34);
    check("recip_sat", 192'(dut.u_div.recip), 192'(24'hFFFFFF));

    // Zero divisor
    c = cyc;
    send(20'h00000, h3, 1'b1, q0, GUARD);
    goto(c + 34);
    check("recip_zero", 192'(dut.u_div.recip), 192'(24'hFFFFFF));

    // Rii = 1.5: exercises round half up on both signs
    c = cyc;
    send(20'h18000, h4, 1'b1, q4, 1'b0);
    goto(c + 34);
    check("recip_1p5", 192'(dut.u_div.recip), 192'(24'h0AAAAA));

    // Overrun: strobe at cycle 10 dropped, strobe at cycle 33 accepted
    c = cyc;
    send(20'h10000, h1, 1'b1, q1, 1'b0);
    goto(c + 10);
    send(20'h20000, h2, 1'b0, q2, 1'b0);
    check("overrun_set", 192'(o_overrun), 192'(1));
    check("overrun_busy", 192'(o_ready), 192'(0));
    goto(c + 33);
    check("ready_c33", 192'(o_ready), 192'(1));
    send(20'h18000, h4, 1'b1, q4, 1'b0);
    goto(c + 50);
    check("column_held", 192'(o_q_column), 192'(q1));
    check("overrun_sticky", 192'(o_overrun), 192'(1));
    goto(c + 67);

    // Reset at cycle 20 aborts the job
    c = cyc;
    send(20'h10000, h2, 1'b0, q2, 1'b0);
    goto(c + 20);
    i_rst_n = 1'b0;
    #1;
    check("abort_valid", 192'(o_q_valid), 192'(0));
    check("abort_column", 192'(o_q_column), 192'(0));
    check("abort_overrun", 192'(o_overrun), 192'(0));
    check("abort_ready", 192'(o_ready), 192'(1));
    goto(c + 23);
    i_rst_n = 1'b1;
    v0 = valids_seen;
    goto(c + 60);
    check("abort_no_valid", 192'(valids_seen), 192'(v0));
    check("abort_ready_after", 192'(o_ready), 192'(1));

    // Recovery after reset
    c = cyc;
    send(20'h20000, h2, 1'b1, q2, 1'b0);
    goto(c + 36);

    check("queue_drained", 192'(exp_q.size()), 192'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
